// File: rtl/lcd_text_scan_pkg.sv
// Shared constants, FSM state type and helpers for the character-LCD refresh engine.
package lcd_text_scan_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    POWER_WAIT,
    INIT,
    ADDR,
    FETCH,
    WRITE
  } scan_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_scan_write_phy.sv
// Single-byte HD44780 write strobe: setup cycle, E high, then a settle gap.
module lcd_write_phy #(
  parameter int unsigned E_HIGH  = 25,
  parameter int unsigned CMD_GAP = 2500,
  parameter int unsigned CLR_GAP = 100000,
  parameter int unsigned CW      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_gap,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_SETUP = 2'd1;
  localparam logic [1:0] P_HIGH  = 2'd2;
  localparam logic [1:0] P_GAP   = 2'd3;

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          long_q;
  logic [CW-1:0] gap_last;

  assign gap_last = long_q ? CW'(CLR_GAP - 1) : CW'(CMD_GAP - 1);
  assign lcd_e    = (state_q == P_HIGH);
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign busy     = (state_q != P_IDLE);
  assign done     = (state_q == P_GAP) && (cnt_q == gap_last);

  // rs/data stay latched after done so the bus is stable through the gap and beyond
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      case (state_q)
        P_IDLE: begin
          if (start) begin
            rs_q    <= rs;
            data_q  <= data;
            long_q  <= long_gap;
            cnt_q   <= '0;
            state_q <= P_SETUP;
          end
        end
        P_SETUP: begin
          cnt_q   <= '0;
          state_q <= P_HIGH;
        end
        P_HIGH: begin
          if (cnt_q == CW'(E_HIGH - 1)) begin
            cnt_q   <= '0;
            state_q <= P_GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        P_GAP: begin
          if (done) begin
            cnt_q   <= '0;
            state_q <= P_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_scan.sv
// 2x16 character-LCD refresh engine: controller init, then an endless 32-character sweep.
module lcd_text_scan
  import lcd_text_scan_pkg::*;
#(
  parameter int unsigned INIT_WAIT = 750000,
  parameter int unsigned E_HIGH    = 25,
  parameter int unsigned CMD_GAP   = 2500,
  parameter int unsigned CLR_GAP   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(max3(INIT_WAIT, CLR_GAP, E_HIGH) + 1);

  scan_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    step_q;
  logic          issued_q;
  logic [4:0]    index_q;
  logic [7:0]    char_q;
  logic          init_done_q;
  logic          frame_done_q;

  logic       phy_start;
  logic       phy_rs;
  logic [7:0] phy_data;
  logic       phy_long;
  logic       phy_busy;
  logic       phy_done;

  assign index      = index_q;
  assign lcd_rw     = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

  // issued_q marks that the current state's byte has been handed to the phy
  always_comb begin
    phy_start = 1'b0;
    phy_rs    = 1'b0;
    phy_data  = 8'h00;
    phy_long  = 1'b0;
    unique case (state_q)
      INIT: begin
        phy_start = !issued_q && !phy_busy;
        phy_data  = init_cmd(step_q);
        phy_long  = (step_q == 2'd2);
      end
      ADDR: begin
        phy_start = !issued_q && !phy_busy;
        phy_data  = index_q[4] ? LCD_LINE2 : LCD_LINE1;
      end
      WRITE: begin
        phy_start = !issued_q && !phy_busy;
        phy_rs    = 1'b1;
        phy_data  = char_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= POWER_WAIT;
      cnt_q        <= '0;
      step_q       <= 2'd0;
      issued_q     <= 1'b0;
      index_q      <= 5'd0;
      char_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (phy_start) issued_q <= 1'b1;
      case (state_q)
        POWER_WAIT: begin
          if (cnt_q == CW'(INIT_WAIT)) begin
            cnt_q   <= '0;
            step_q  <= 2'd0;
            state_q <= INIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        INIT: begin
          if (phy_done) begin
            issued_q <= 1'b0;
            if (step_q == 2'd3) begin
              init_done_q <= 1'b1;
              index_q     <= 5'd0;
              state_q     <= ADDR;
            end else begin
              step_q <= step_q + 2'd1;
            end
          end
        end
        ADDR: begin
          if (phy_done) begin
            issued_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          // Two stable cycles absorb the source's registered lookup
          if (cnt_q == CW'(1)) begin
            char_q  <= char_in;
            cnt_q   <= '0;
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WRITE: begin
          if (phy_done) begin
            issued_q <= 1'b0;
            cnt_q    <= '0;
            if (index_q == 5'd15) begin
              index_q <= 5'd16;
              state_q <= ADDR;
            end else if (index_q == 5'd31) begin
              index_q      <= 5'd0;
              frame_done_q <= 1'b1;
              state_q      <= ADDR;
            end else begin
              index_q <= index_q + 5'd1;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= POWER_WAIT;
      endcase
    end
  end

  lcd_write_phy #(
    .E_HIGH (E_HIGH),
    .CMD_GAP(CMD_GAP),
    .CLR_GAP(CLR_GAP),
    .CW     (CW)
  ) u_phy (
    .clk     (clk),
    .rst     (rst),
    .start   (phy_start),
    .rs      (phy_rs),
    .data    (phy_data),
    .long_gap(phy_long),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_data(lcd_data),
    .busy    (phy_busy),
    .done    (phy_done)
  );

endmodule

// File: tb/tb_lcd_text_scan.sv
// Bench for lcd_text_scan: per-cycle timeline model plus literal checks on captured bytes.
module tb_lcd_text_scan;

  localparam int unsigned INIT_WAIT = 10;
  localparam int unsigned E_HIGH    = 2;
  localparam int unsigned CMD_GAP   = 4;
  localparam int unsigned CLR_GAP   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic       init_done, frame_done;

  lcd_text_scan #(
    .INIT_WAIT(INIT_WAIT),
    .E_HIGH   (E_HIGH),
    .CMD_GAP  (CMD_GAP),
    .CLR_GAP  (CLR_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .index     (index),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Character source: registered lookup, one clock behind index
  logic [7:0] chars [0:4][0:31];
  int src_frame = 0;
  always @(posedge clk) char_in <= chars[src_frame][index];

  typedef struct {
    bit       e;
    bit       rs;
    bit [7:0] d;
    bit [4:0] idx;
    bit       init;
    bit       fd;
    int       frame;
  } rec_t;

  typedef struct {
    bit       rs;
    bit [7:0] d;
    int       rise;
    int       fall;
  } cap_t;

  rec_t tl[$];
  cap_t caps[$];
  rec_t last;

  bit       m_rs, m_init, m_fd;
  bit [7:0] m_d;
  bit [4:0] m_idx;
  int       m_frame;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, rise_c, init_rise, fd_cnt, fd_first;
  bit prev_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, got, want);
    end
  endtask

  function automatic void push(input bit e);
    rec_t r;
    r.e = e; r.rs = m_rs; r.d = m_d; r.idx = m_idx; r.init = m_init;
    r.fd = m_fd; r.frame = m_frame;
    m_fd = 1'b0;
    tl.push_back(r);
  endfunction

  // One byte as seen on the pins: handoff, setup, E high, gap
  function automatic void put_byte(input bit rs, input bit [7:0] d, input int gap);
    push(1'b0);
    m_rs = rs;
    m_d  = d;
    push(1'b0);
    repeat (E_HIGH) push(1'b1);
    repeat (gap) push(1'b0);
  endfunction

  function automatic void build_tl();
    tl.delete();
    m_rs = 0; m_init = 0; m_fd = 0; m_d = 8'h00; m_idx = 5'd0; m_frame = 0;
    repeat (INIT_WAIT) push(1'b0);
    put_byte(1'b0, 8'h38, CMD_GAP);
    put_byte(1'b0, 8'h0C, CMD_GAP);
    put_byte(1'b0, 8'h01, CLR_GAP);
    put_byte(1'b0, 8'h06, CMD_GAP);
    m_init = 1'b1;
    for (int f = 0; f < 5; f++) begin
      m_frame = f;
      put_byte(1'b0, 8'h80, CMD_GAP);
      for (int i = 0; i < 32; i++) begin
        if (i == 16) put_byte(1'b0, 8'hC0, CMD_GAP);
        push(1'b0);
        push(1'b0);
        put_byte(1'b1, chars[f][i], CMD_GAP);
        if (i == 31) m_fd = 1'b1;
        m_idx = m_idx + 5'd1;
      end
    end
  endfunction

  // {rs, data} of byte k of a frame whose characters are 0x41 + index
  function automatic logic [8:0] letter_byte(input int k);
    if (k == 0)  return {1'b0, 8'h80};
    if (k == 17) return {1'b0, 8'hC0};
    if (k < 17)  return {1'b1, 8'h41 + 8'(k - 1)};
    return {1'b1, 8'h41 + 8'(k - 2)};
  endfunction

  task automatic restart_tracking();
    cyc = 0; rise_c = 0; init_rise = 0; fd_cnt = 0; fd_first = 0; prev_e = 1'b0;
    caps.delete();
  endtask

  task automatic step();
    rec_t r;
    cap_t c;
    @(negedge clk);
    cyc++;
    if (tl.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeline @cycle %0d: got empty model, want a record", cyc);
      return;
    end
    r = tl.pop_front();
    last = r;
    src_frame = r.frame;
    chk("lcd_e", 32'(lcd_e), 32'(r.e));
    chk("lcd_rs", 32'(lcd_rs), 32'(r.rs));
    chk("lcd_data", 32'(lcd_data), 32'(r.d));
    chk("lcd_rw", 32'(lcd_rw), 32'(0));
    chk("index", 32'(index), 32'(r.idx));
    chk("init_done", 32'(init_done), 32'(r.init));
    chk("frame_done", 32'(frame_done), 32'(r.fd));
    if (lcd_e && !prev_e) rise_c = cyc;
    if (!lcd_e && prev_e) begin
      c.rs = lcd_rs; c.d = lcd_data; c.rise = rise_c; c.fall = cyc;
      caps.push_back(c);
    end
    prev_e = lcd_e;
    if (init_done && init_rise == 0) init_rise = cyc;
    if (frame_done) begin
      fd_cnt++;
      if (fd_first == 0) fd_first = cyc;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " lcd_e"}, 32'(lcd_e), 32'(0));
    chk({tag, " lcd_rs"}, 32'(lcd_rs), 32'(0));
    chk({tag, " lcd_data"}, 32'(lcd_data), 32'(0));
    chk({tag, " index"}, 32'(index), 32'(0));
    chk({tag, " init_done"}, 32'(init_done), 32'(0));
    chk({tag, " frame_done"}, 32'(frame_done), 32'(0));
  endtask

  initial begin
    int skip;
    bit hit;
    logic [8:0] w;
    for (int f = 0; f < 5; f++)
      for (int i = 0; i < 32; i++)
        chars[f][i] = (f < 3) ? 8'h41 + 8'(i) : 8'($urandom_range(32'h20, 32'h7E));
    chars[2][12] = 8'h2E;
    chars[3][12] = 8'h20;
    chars[4][12] = 8'h2E;

    rst = 1'b1;
    restart_tracking();
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end

    build_tl();
    rst = 1'b0;
    skip = $urandom_range(0, 30);
    hit = 1'b0;
    while (!hit && tl.size() > 0) begin
      step();
      if (last.frame == 4 && last.e) begin
        if (skip == 0) hit = 1'b1;
        else skip--;
      end
    end

    // Literal expectations on what the LCD actually latched
    if (caps.size() >= 4 + 34 * 4) begin
      chk("first E rise cycle", 32'(caps[0].rise), 32'(13));
      chk("first E width", 32'(caps[0].fall - caps[0].rise), 32'(2));
      chk("init0", {23'd0, caps[0].rs, caps[0].d}, {23'd0, 1'b0, 8'h38});
      chk("init1", {23'd0, caps[1].rs, caps[1].d}, {23'd0, 1'b0, 8'h0C});
      chk("init2", {23'd0, caps[2].rs, caps[2].d}, {23'd0, 1'b0, 8'h01});
      chk("init3", {23'd0, caps[3].rs, caps[3].d}, {23'd0, 1'b0, 8'h06});
      chk("gap after 0x38 >= 4", 32'(caps[1].rise - caps[0].fall >= 4), 32'(1));
      chk("gap after 0x0C >= 4", 32'(caps[2].rise - caps[1].fall >= 4), 32'(1));
      chk("gap after 0x01 >= 8", 32'(caps[3].rise - caps[2].fall >= 8), 32'(1));
      chk("init_done rise", 32'(init_rise), 32'(caps[3].fall + 4));
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < 34; k++) begin
          w = letter_byte(k);
          chk($sformatf("frame%0d byte%0d", f, k),
              {23'd0, caps[4 + 34 * f + k].rs, caps[4 + 34 * f + k].d}, {23'd0, w});
        end
      chk("frame2 pos12", 32'(caps[4 + 34 * 2 + 13].d), 32'h2E);
      chk("frame3 pos12", 32'(caps[4 + 34 * 3 + 13].d), 32'h20);
      chk("first frame_done cycle", 32'(fd_first), 32'(caps[4 + 33].fall + 4));
    end else begin
      chk("captured byte count", 32'(caps.size()), 32'(4 + 34 * 4));
    end
    chk("frame_done pulses before reset", 32'(fd_cnt), 32'(4));
    chk("reset point reached", 32'(hit), 32'(1));

    // Reset for one cycle while E is high
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid-strobe reset");
    build_tl();
    restart_tracking();
    rst = 1'b0;
    repeat (120) step();
    if (caps.size() > 0) begin
      chk("restart first E rise", 32'(caps[0].rise), 32'(13));
      chk("restart first byte", {23'd0, caps[0].rs, caps[0].d}, {23'd0, 1'b0, 8'h38});
    end else begin
      chk("restart captured bytes", 32'(caps.size()), 32'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
